// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI types and constants for the master and the slave bridge
package spi_pkg;
    typedef enum logic [2:0] {IDLE, SETUP, XFER, WAIT, HOLD, GAP} spi_state_e;
    localparam int SPI_FRAME_BITS = 8;
    localparam bit SPI_CPOL = 1'b0;
    localparam bit SPI_CPHA = 1'b0;
endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: half-period divider, one tick every CLK_DIV enabled cycles
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic sclk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);
    logic [7:0] cnt_q;
    assign tick_o = en_i && cnt_q == 8'(CLK_DIV - 1);
    always_ff @(posedge sclk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else if (clr_i) cnt_q <= '0;
        else if (en_i) cnt_q <= tick_o ? '0 : cnt_q + 8'd1;
endmodule

// File: rtl/spi_master_tx.sv
// spi_master_tx: mode-0 SPI master, MSB first, bursts under one chip select.
// Define SPI_MASTER_LOOPBACK_EN to add a loopback input that samples MOSI instead of MISO.
module spi_master_tx
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 2
) (
    input  logic       sclk,
    input  logic       rst_n,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       spi_sck,
    output logic       spi_cs_n,
    output logic       spi_mosi,
    input  logic       spi_miso
`ifdef SPI_MASTER_LOOPBACK_EN
    ,
    input  logic       loopback
`endif
);
    spi_state_e state_q, state_d;
    logic       accept, tick, div_en, div_clr, rise_tick, fall_tick, last_bit, sample;
    logic [7:0] tx_sh_q, rx_sh_q, rx_data_q, gap_cnt_q;
    logic [2:0] bit_cnt_q;
    logic       last_q, sck_q, cs_n_q, mosi_q, rx_valid_q;

    if (CLK_DIV < 2) begin : g_bad_div
        $error("spi_master_tx: CLK_DIV must be at least 2");
    end

    assign accept    = tx_valid && tx_ready;
    assign rise_tick = tick && state_q == XFER && !sck_q;
    assign fall_tick = tick && state_q == XFER && sck_q;
    assign last_bit  = bit_cnt_q == 3'(SPI_FRAME_BITS - 1);
    assign div_clr   = state_d != state_q;
`ifdef SPI_MASTER_LOOPBACK_EN
    assign sample = loopback ? mosi_q : spi_miso;
`else
    assign sample = spi_miso;
`endif

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .sclk   (sclk),
        .rst_n  (rst_n),
        .en_i   (div_en),
        .clr_i  (div_clr),
        .tick_o (tick)
    );

    always_ff @(posedge sclk or negedge rst_n)
        if (!rst_n) state_q <= IDLE;
        else state_q <= state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, WAIT: state_d = accept ? SETUP : state_q;
            SETUP:      state_d = tick ? XFER : SETUP;
            XFER:       state_d = (fall_tick && last_bit) ? (last_q ? HOLD : WAIT) : XFER;
            HOLD:       state_d = tick ? GAP : HOLD;
            GAP:        state_d = (tick && gap_cnt_q == 8'(CS_GAP - 1)) ? IDLE : GAP;
            default:    state_d = IDLE;
        endcase
    end

    // tx_ready is gated by rst_n so nothing is offered while reset is held
    always_comb begin
        tx_ready = rst_n && (state_q == IDLE || state_q == WAIT);
        busy     = state_q != IDLE;
        div_en   = !(state_q == IDLE || state_q == WAIT);
    end

    always_ff @(posedge sclk or negedge rst_n)
        if (!rst_n) begin
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            gap_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            last_q     <= 1'b0;
            sck_q      <= SPI_CPOL;
            cs_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            gap_cnt_q  <= state_q != GAP ? '0 : gap_cnt_q + 8'(tick);
            if (accept) begin
                tx_sh_q   <= tx_data;
                mosi_q    <= tx_data[7];
                last_q    <= tx_last;
                bit_cnt_q <= '0;
                cs_n_q    <= 1'b0;
            end
            if (state_q == HOLD && tick) cs_n_q <= 1'b1;
            if (tick && state_q == XFER) sck_q <= ~sck_q;
            if (rise_tick) rx_sh_q <= {rx_sh_q[6:0], sample};
            if (fall_tick) begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
                if (last_bit) begin
                    rx_data_q  <= rx_sh_q;
                    rx_valid_q <= 1'b1;
                end else begin
                    tx_sh_q <= tx_sh_q << 1;
                    mosi_q  <= tx_sh_q[6];
                end
            end
        end

    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign spi_sck  = sck_q;
    assign spi_cs_n = cs_n_q;
    assign spi_mosi = mosi_q;
endmodule

// File: tb/tb_spi_master_tx.sv
// tb_spi_master_tx: directed checks of spi_master_tx (CLK_DIV=4, CS_GAP=2) against a mode-0 slave model
module tb_spi_master_tx;
    logic       sclk = 1'b0, rst_n = 1'b0, tx_valid = 1'b0, tx_last = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, rx_valid, busy, spi_sck, spi_cs_n, spi_mosi, spi_miso;
    logic [7:0] rx_data;
    logic       miso_zero = 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
    logic       loopback = 1'b0;
`endif
    int vecs = 0, errs = 0;
    int rises = 0, rxv_cnt = 0, cs_rises = 0, gap_rdy = 0;
    time t_cs_rise = 0, t_cs_fall = 0, t_sck_fall = 0;
    logic [7:0] s_sh = 8'h00, s_rx = 8'h00, s_reply = 8'h00;
    int s_cnt = 0;
    logic cs_prev = 1'b1;

    always #5 sclk = ~sclk;

    spi_master_tx #(.CLK_DIV(4), .CS_GAP(2)) dut (
        .sclk     (sclk),
        .rst_n    (rst_n),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_last  (tx_last),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .busy     (busy),
        .spi_sck  (spi_sck),
        .spi_cs_n (spi_cs_n),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
`ifdef SPI_MASTER_LOOPBACK_EN
        ,
        .loopback (loopback)
`endif
    );

    assign spi_miso = miso_zero ? 1'b0 : s_sh[7];

    // mode-0 slave: shift out on falling sck, capture MOSI on rising sck
    always @(posedge spi_cs_n or negedge spi_cs_n or posedge spi_sck or negedge spi_sck) begin
        if (cs_prev && !spi_cs_n) begin
            s_sh = s_reply;
            s_cnt = 0;
        end else if (!spi_cs_n && spi_sck) begin
            s_rx = {s_rx[6:0], spi_mosi};
            s_cnt++;
            rises++;
        end else if (!spi_cs_n && !spi_sck) begin
            if (s_cnt == 8) begin
                s_sh = s_reply;
                s_cnt = 0;
            end else s_sh = s_sh << 1;
        end
        cs_prev = spi_cs_n;
    end

    always @(posedge sclk) begin
        if (rx_valid) rxv_cnt++;
        if (rst_n && spi_cs_n && busy && tx_ready) gap_rdy++;
    end
    always @(posedge spi_cs_n) begin
        t_cs_rise = $time;
        cs_rises++;
    end
    always @(negedge spi_cs_n) t_cs_fall = $time;
    always @(negedge spi_sck) t_sck_fall = $time;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic l, output time acc);
        int n = 0;
        tx_valid = 1'b1;
        tx_data = d;
        tx_last = l;
        while (!tx_ready && n < 2000) begin
            @(posedge sclk); #1; n++;
        end
        chk("accept_wait", 32'(n < 2000), 32'd1);
        @(posedge sclk);
        acc = $time;
        #1;
        tx_valid = 1'b0;
    endtask

    task automatic wait_rx(output time t);
        int n = 0;
        do begin
            @(posedge sclk); #1; n++;
        end while (!rx_valid && n < 2000);
        chk("rx_wait", 32'(n < 2000), 32'd1);
        t = $time - 1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 2000) begin
            @(posedge sclk); #1; n++;
        end
        chk("idle_wait", 32'(n < 2000), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        time acc, t;
        int r0, v0, c0, g0, n;
        repeat (3) @(posedge sclk);
        #1;
        chk("rst_tx_ready", 32'(tx_ready), 32'd0);
        chk("rst_cs_n", 32'(spi_cs_n), 32'd1);
        chk("rst_sck", 32'(spi_sck), 32'd0);
        chk("rst_mosi", 32'(spi_mosi), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("idle_tx_ready", 32'(tx_ready), 32'd1);

        // single byte 0xA5, slave answers 0x3C
        @(posedge sclk); #1;
        s_reply = 8'h3C;
        send(8'hA5, 1'b1, acc);
        chk("t1_mosi_bit7", 32'(spi_mosi), 32'd1);
        chk("t1_cs_low", 32'(spi_cs_n), 32'd0);
        wait_rx(t);
        chk("t1_latency", 32'((t - acc) / 10), 32'd68);
        chk("t1_rx_data", 32'(rx_data), 32'h3C);
        wait_idle();
        chk("t1_slave_rx", 32'(s_rx), 32'hA5);
        chk("t1_cs_after_sck", 32'((t_cs_rise - t_sck_fall) / 10), 32'd4);

        // burst of three bytes under one chip select
        s_reply = 8'h5A;
        r0 = rises; v0 = rxv_cnt; c0 = cs_rises;
        send(8'h01, 1'b0, acc);
        wait_rx(t);
        chk("t2_rx0", 32'(rx_data), 32'h5A);
        chk("t2_slave0", 32'(s_rx), 32'h01);
        chk("t2_wait_ready", 32'(tx_ready), 32'd1);
        chk("t2_wait_cs", 32'(spi_cs_n), 32'd0);
        send(8'h02, 1'b0, acc);
        wait_rx(t);
        chk("t2_slave1", 32'(s_rx), 32'h02);
        send(8'h03, 1'b1, acc);
        wait_rx(t);
        chk("t2_rx2", 32'(rx_data), 32'h5A);
        chk("t2_slave2", 32'(s_rx), 32'h03);
        chk("t2_cs_held", 32'(cs_rises - c0), 32'd0);
        wait_idle();
        chk("t2_rises", 32'(rises - r0), 32'd24);
        chk("t2_rx_pulses", 32'(rxv_cnt - v0), 32'd3);

        // 0x55 held on the stream while 0xAA shifts out
        s_reply = 8'h96;
        v0 = rxv_cnt;
        send(8'hAA, 1'b0, acc);
        tx_valid = 1'b1; tx_data = 8'h55; tx_last = 1'b1;
        n = 0;
        while (!tx_ready && n < 2000) begin
            @(posedge sclk); #1; n++;
        end
        chk("t3_ready_delay", 32'(n), 32'd68);
        chk("t3_rx_at_wait", 32'(rx_valid), 32'd1);
        chk("t3_slave_aa", 32'(s_rx), 32'hAA);
        send(8'h55, 1'b1, acc);
        wait_rx(t);
        chk("t3_slave_55", 32'(s_rx), 32'h55);
        chk("t3_rx_data", 32'(rx_data), 32'h96);
        wait_idle();
        chk("t3_rx_pulses", 32'(rxv_cnt - v0), 32'd2);

        // reset at the 4th rising sck aborts the frame
        s_reply = 8'h33;
        v0 = rxv_cnt; r0 = rises;
        send(8'h12, 1'b1, acc);
        n = 0;
        while (rises - r0 < 4 && n < 2000) begin
            @(posedge sclk); #1; n++;
        end
        chk("t4_reach_rise4", 32'(n < 2000), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t4_cs_n", 32'(spi_cs_n), 32'd1);
        chk("t4_sck", 32'(spi_sck), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        repeat (5) @(posedge sclk);
        #1;
        chk("t4_no_rx", 32'(rxv_cnt - v0), 32'd0);
        rst_n = 1'b1;
        s_reply = 8'hFF;
        send(8'hFF, 1'b1, acc);
        wait_rx(t);
        chk("t4_rx_ff", 32'(rx_data), 32'hFF);
        chk("t4_slave_ff", 32'(s_rx), 32'hFF);
        chk("t4_latency", 32'((t - acc) / 10), 32'd68);
        wait_idle();

        // back-to-back single-byte frames
        s_reply = 8'h0F;
        g0 = gap_rdy;
        send(8'h11, 1'b1, acc);
        send(8'h22, 1'b1, acc);
        chk("t5_cs_gap", 32'((t_cs_fall - t_cs_rise) / 10), 32'd9);
        wait_rx(t);
        chk("t5_rx", 32'(rx_data), 32'h0F);
        wait_idle();
        chk("t5_slave", 32'(s_rx), 32'h22);
        chk("t5_gap_not_ready", 32'(gap_rdy - g0), 32'd0);

`ifdef SPI_MASTER_LOOPBACK_EN
        loopback = 1'b1;
        miso_zero = 1'b1;
        send(8'hC3, 1'b1, acc);
        wait_rx(t);
        chk("t6_loopback", 32'(rx_data), 32'hC3);
        wait_idle();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/spi_master_tx.md
Name: spi_master_tx

Overview:
- SPI master (initiator) driving the peripheral-side SPI slave bridge; mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames.
- Accepts bytes from a local valid/ready stream, serialises them on MOSI, and captures MISO into a received byte per frame.
- Supports multi-byte bursts under one chip-select assertion, for register read/write sequences from the test/host side.

Parameters:
- CLK_DIV, 4, sclk cycles per SPI clock half-period; legal range 2..255.
- CS_GAP, 2, minimum number of half-periods spi_cs_n stays high between bursts.

Ports:
- sclk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- tx_valid  in  1  byte offered.
- tx_ready  out  1  block can accept a byte.
- tx_data  in  8  byte to transmit.
- tx_last  in  1  sampled with tx_data; 1 = release CS after this byte.
- rx_valid  out  1  one-cycle pulse; rx_data valid.
- rx_data  out  8  byte captured from MISO.
- busy  out  1  high whenever spi_cs_n is low or a CS gap is running.
- spi_sck  out  1  serial clock, idle low.
- spi_cs_n  out  1  chip select, active-low.
- spi_mosi  out  1  master out.
- spi_miso  in  1  master in.

Behaviour:
- Reset values: spi_sck=0, spi_cs_n=1, spi_mosi=0, tx_ready=0 during reset then 1 in IDLE, rx_valid=0, rx_data=0, busy=0; FSM=IDLE, counters=0.
- Reset mid-frame aborts immediately: no rx_valid, CS deasserts asynchronously.
- Handshake: transfer occurs when tx_valid && tx_ready. tx_ready=1 only in IDLE and WAIT. tx_data/tx_last are latched on acceptance.
- Divider: div_cnt counts 0..CLK_DIV-1; a tick occurs at CLK_DIV-1. Each tick in XFER toggles spi_sck.
- FSM states:
  - IDLE: cs_n=1. On accept, load shift register, drive spi_mosi=tx_data[7], cs_n=0, go to SETUP.
  - SETUP: hold one half-period (CLK_DIV cycles), sck low, then go to XFER.
  - XFER: 16 ticks.
    - Rising tick: sample spi_miso into rx shift (LSB in).
    - Falling tick: present next MOSI bit. No MOSI change after the 8th falling tick.
    - On the 8th falling tick: rx_data updated, rx_valid=1 for exactly that cycle+1 register stage, i.e. accept cycle + 17*CLK_DIV.
    - Then go to HOLD if last, else WAIT.
  - WAIT: cs_n stays 0, sck 0, tx_ready=1. On accept, drive bit7 and go to SETUP.
  - HOLD: one half-period with cs_n=0, then cs_n=1 and go to GAP.
  - GAP: CS_GAP half-periods with cs_n=1, tx_ready=0, busy=1, then go to IDLE.
- Simultaneous events:
  - A tx_valid arriving during XFER is not accepted (tx_ready=0) and must stay held.
  - Accept in IDLE on the same cycle reset deasserts is legal.
- Boundaries:
  - The bit counter wraps 7→0 only in XFER.
  - WAIT has no timeout; the burst is held open indefinitely.
  - CLK_DIV<2 is flagged with an elaboration-time $error.

Optional Feature:
- Macro: SPI_MASTER_LOOPBACK_EN.
- Defined: adds input port loopback (1 bit, after spi_miso). When loopback=1, the rising-tick sample uses the internal MOSI register instead of spi_miso, so rx_data equals the transmitted byte. spi_miso is ignored; pins still toggle.
- Undefined: no port and no mux; the sample always comes from spi_miso.

Decomposition:
- Shared package spi_pkg:
  - FSM state enum (IDLE, SETUP, XFER, WAIT, HOLD, GAP).
  - SPI_FRAME_BITS=8.
  - SPI_CPOL=0, SPI_CPHA=0 constants, shared with the slave bridge.
- Sub-module spi_clk_div: div_cnt plus tick output, enable input, synchronous clear on state entry.

Test Plan:
- CLK_DIV=4: send 0xA5 (tx_last=1) to a slave model returning 0x3C.
  - MOSI bits 1,0,1,0,0,1,0,1 are stable at each rising sck.
  - rx_data=0x3C.
  - rx_valid occurs at accept+68.
  - cs_n rises 4 cycles after the last falling sck.
- Burst 0x01,0x02,0x03, last on the third byte: cs_n stays low throughout, with 3 rx_valid pulses and 24 rising sck edges; WAIT shows tx_ready=1 between bytes.
- Hold tx_valid with 0x55 during XFER of 0xAA: tx_ready=0 until WAIT/IDLE; 0x55 is transmitted next, with no byte lost or duplicated.
- Assert rst_n low at the 4th rising sck: cs_n=1 and sck=0 immediately; no rx_valid; the next transfer after reset is clean (0xFF→0xFF via slave echo).
- Back-to-back single bytes: spi_cs_n high for ≥ CS_GAP*CLK_DIV=8 cycles between frames; tx_ready=0 during GAP.
- With SPI_MASTER_LOOPBACK_EN and loopback=1, spi_miso tied to 0: sending 0xC3 yields rx_data=0xC3.
